// File: rtl/mc_ctrl_if.sv
// Bundles the IR fields, ALU flags, memory handshake and datapath controls between sequencer and datapath.
interface mc_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       rf_we;
  logic [1:0] wd_sel;
  logic [1:0] alusrc_a;
  logic [1:0] alusrc_b;
  logic [1:0] alu_op;
  logic [5:0] ext_op;
  logic       trap;

  modport master (
    input  opcode, funct3, funct7b5, zero, lt, ltu, mem_ack,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wd_sel,
           alusrc_a, alusrc_b, alu_op, ext_op, trap
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, lt, ltu, mem_ack,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wd_sel,
           alusrc_a, alusrc_b, alu_op, ext_op, trap
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memory
// handshake, ack timeout and a sticky trap state.
module mc_ctrl_fsm #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IAR   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [7:0] LIM      = 8'(ACK_TIMEOUT);

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [5:0] w_ext;
  logic       w_valid, w_is_store, w_is_load, w_limit, w_taken, w_br_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_is_store = (bus.opcode == OP_STORE);
  assign w_is_load  = (bus.opcode == OP_LOAD);
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_limit    = (ACK_TIMEOUT != 0) && (w_cnt_inc == LIM);

  // Immediate format and legality; SLLI needs funct7b5=0, SRLI/SRAI take either value.
  always_comb begin
    w_ext   = 6'b000000;
    w_valid = 1'b1;
    case (bus.opcode)
      OP_IAR: begin
        if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) begin
          w_ext = 6'b100000;
          if (bus.funct3 == 3'b001 && bus.funct7b5) w_valid = 1'b0;
        end else begin
          w_ext = 6'b010000;
        end
      end
      OP_LOAD, OP_JALR:  w_ext = 6'b010000;
      OP_STORE:          w_ext = 6'b001000;
      OP_BR:             w_ext = 6'b000100;
      OP_LUI, OP_AUIPC:  w_ext = 6'b000010;
      OP_JAL:            w_ext = 6'b000001;
      OP_R:              w_ext = 6'b000000;
      default:           w_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_taken  = 1'b0;
    w_br_bad = 1'b0;
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = !bus.zero;
      3'b100:  w_taken = bus.lt;
      3'b101:  w_taken = !bus.lt;
      3'b110:  w_taken = bus.ltu;
      3'b111:  w_taken = !bus.ltu;
      default: w_br_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = 2'd0;
    bus.rf_we    = 1'b0;
    bus.wd_sel   = 2'd0;
    bus.alusrc_a = 2'd0;
    bus.alusrc_b = 2'd0;
    bus.alu_op   = 2'd0;
    bus.ext_op   = 6'b000000;
    bus.trap     = 1'b0;
    case (r_state)
      S_RST: w_state_next = S_FETCH;
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.alusrc_a = 2'd1;
        bus.alusrc_b = 2'd2;
        if (bus.mem_ack) begin
          bus.ir_we    = 1'b1;
          bus.pc_we    = 1'b1;
          w_cnt_next   = 8'd0;
          w_state_next = S_DECODE;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_limit) w_state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        bus.alusrc_a = 2'd2;
        bus.alusrc_b = 2'd1;
        bus.ext_op   = w_ext;
        w_state_next = w_valid ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        bus.ext_op   = w_ext;
        w_state_next = S_WB;
        case (bus.opcode)
          OP_R: begin
            bus.alu_op = 2'd2;
          end
          OP_IAR: begin
            bus.alusrc_b = 2'd1;
            bus.alu_op   = 2'd3;
          end
          OP_LOAD, OP_STORE: begin
            bus.alusrc_b = 2'd1;
            w_state_next = S_MEM;
          end
          OP_LUI: begin
            bus.alusrc_a = 2'd3;
            bus.alusrc_b = 2'd1;
          end
          OP_AUIPC: begin
            bus.alusrc_a = 2'd2;
            bus.alusrc_b = 2'd1;
          end
          OP_BR: begin
            bus.alu_op   = 2'd1;
            bus.pc_we    = w_taken;
            bus.pc_sel   = w_taken ? 2'd1 : 2'd0;
            w_state_next = w_br_bad ? S_TRAP : S_FETCH;
          end
          OP_JAL: begin
            bus.pc_we    = 1'b1;
            bus.pc_sel   = 2'd1;
            bus.rf_we    = 1'b1;
            bus.wd_sel   = 2'd2;
            w_state_next = S_FETCH;
          end
          OP_JALR: begin
            bus.alusrc_b = 2'd1;
            bus.pc_we    = 1'b1;
            bus.pc_sel   = 2'd2;
            bus.rf_we    = 1'b1;
            bus.wd_sel   = 2'd2;
            w_state_next = S_FETCH;
          end
          default: w_state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = w_is_store;
        bus.ext_op   = w_ext;
        if (bus.mem_ack) begin
          w_cnt_next   = 8'd0;
          w_state_next = w_is_store ? S_FETCH : S_WB;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_limit) w_state_next = S_TRAP;
        end
      end
      S_WB: begin
        bus.rf_we    = 1'b1;
        bus.wd_sel   = w_is_load ? 2'd1 : 2'd0;
        bus.ext_op   = w_ext;
        w_state_next = S_FETCH;
      end
      S_TRAP: bus.trap = 1'b1;
      default: w_state_next = S_TRAP;
    endcase
    // Every fresh wait phase starts its timeout from zero.
    if ((w_state_next == S_FETCH || w_state_next == S_MEM) && w_state_next != r_state)
      w_cnt_next = 8'd0;
  end
endmodule
